// File: rtl/iec_fast_pkg.sv
// Shared types and constants for the IEC fast-serial host port.
//   fs_state_t : TX sequencer states
//   BUS_REL / BUS_LOW : open-collector drive levels (1 = released, 0 = pulled low)
//   HP_W / TO_W : widths of the half-period and RX timeout counters
package iec_fast_pkg;

    typedef enum logic [1:0] {FS_IDLE, FS_LOW, FS_HIGH, FS_FIN} fs_state_t;

    localparam logic BUS_REL = 1'b1;
    localparam logic BUS_LOW = 1'b0;

    localparam int unsigned HP_W = 8;
    localparam int unsigned TO_W = 16;

endpackage

// File: rtl/iec_edge_sync.sv
// Two-flop synchroniser for an asynchronous bus level, plus edge pulses.
// All flops reset to 1 so a released (idle-high) bus produces no edge after reset.
//   i_clk, i_reset : system clock, synchronous active-high reset
//   i_d            : asynchronous bus level
//   o_q            : synchronised level (registered)
//   o_rise_c       : 1-clk pulse on synchronised 0->1 (combinational from flops)
//   o_fall_c       : 1-clk pulse on synchronised 1->0 (combinational from flops)
module iec_edge_sync
    import iec_fast_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic r_s1;
    logic r_s2;
    logic r_s2_d;

    // Metastability stages followed by one history flop for edge detection
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1   <= BUS_REL;
            r_s2   <= BUS_REL;
            r_s2_d <= BUS_REL;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    assign o_q      = r_s2;
    assign o_rise_c = r_s2 & ~r_s2_d;
    assign o_fall_c = ~r_s2 & r_s2_d;

endmodule

// File: rtl/iec_fast_ser_host.sv
// Host-side IEC burst/fast-serial port.
// TX shifts a byte MSB-first on DATA, clocked by FCLK low/high half-bits; the drive samples
// on the FCLK rise. RX assembles bytes from DATA sampled on drive-generated FCLK rises.
//   clk, reset            : system clock, synchronous active-high reset
//   ce                    : timing enable; half-period and timeout counters advance only when 1
//   dir                   : 1 = host transmits, 0 = host receives
//   tx_data, tx_start     : byte and 1-clk send request
//   tx_busy, tx_done      : shift in progress, 1-clk completion pulse
//   rx_data, rx_valid     : last received byte, held valid until rx_ack
//   rx_ack, rx_overrun    : consumer acknowledge, sticky overrun flag
//   iec_data_in/_out      : DATA bus level and drive (0 pulls low)
//   iec_fclk_in/_out      : FCLK/SRQ bus level and drive (0 pulls low)
module iec_fast_ser_host
    import iec_fast_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned RX_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       dir,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    input  logic       iec_data_in,
    input  logic       iec_fclk_in,
    output logic       iec_data_out,
    output logic       iec_fclk_out
);

    localparam logic [HP_W-1:0] HP_LAST = HP_W'(HALF_PERIOD - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RX_TIMEOUT - 1);

    fs_state_t         r_state;
    logic [HP_W-1:0]   r_hp_cnt;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_shreg;
    logic              r_tx_busy;
    logic              r_tx_done;
    logic              r_data_out;
    logic              r_fclk_out;

    logic [7:0]        r_rx_shreg;
    logic [2:0]        r_rxcnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [7:0]        r_rx_data;
    logic              r_rx_valid;
    logic              r_rx_overrun;

    logic              w_fclk_rise;
    logic              w_fclk_sync_unused;
    logic              w_fclk_fall_unused;
    logic              w_data_sync;
    logic              w_data_rise_unused;
    logic              w_data_fall_unused;
    logic              w_rx_on;
    logic              w_rx_complete;

    iec_edge_sync u_fclk_sync (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_d      (iec_fclk_in),
        .o_q      (w_fclk_sync_unused),
        .o_rise_c (w_fclk_rise),
        .o_fall_c (w_fclk_fall_unused)
    );

    iec_edge_sync u_data_sync (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_d      (iec_data_in),
        .o_q      (w_data_sync),
        .o_rise_c (w_data_rise_unused),
        .o_fall_c (w_data_fall_unused)
    );

    // TX sequencer: bus drives are updated only on state transitions, so DATA
    // changes exactly at LOW entry and stays put through the HIGH half-bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FS_IDLE;
            r_hp_cnt   <= '0;
            r_bitcnt   <= '0;
            r_shreg    <= '0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_data_out <= BUS_REL;
            r_fclk_out <= BUS_REL;
        end else begin
            r_tx_done <= 1'b0;
            if ((r_state != FS_IDLE) && !dir) begin
                // Direction turned around mid-byte: release the bus, no completion pulse
                r_state    <= FS_IDLE;
                r_hp_cnt   <= '0;
                r_tx_busy  <= 1'b0;
                r_data_out <= BUS_REL;
                r_fclk_out <= BUS_REL;
            end else begin
                case (r_state)
                    FS_IDLE: begin
                        if (tx_start && dir) begin
                            r_shreg    <= tx_data;
                            r_bitcnt   <= 3'd7;
                            r_hp_cnt   <= '0;
                            r_tx_busy  <= 1'b1;
                            r_data_out <= tx_data[7];
                            r_fclk_out <= BUS_LOW;
                            r_state    <= FS_LOW;
                        end
                    end
                    FS_LOW: begin
                        if (ce) begin
                            if (r_hp_cnt == HP_LAST) begin
                                r_hp_cnt   <= '0;
                                r_fclk_out <= BUS_REL;
                                r_state    <= FS_HIGH;
                            end else begin
                                r_hp_cnt <= r_hp_cnt + HP_W'(1);
                            end
                        end
                    end
                    FS_HIGH: begin
                        if (ce) begin
                            if (r_hp_cnt == HP_LAST) begin
                                r_hp_cnt <= '0;
                                if (r_bitcnt == 3'd0) begin
                                    r_state <= FS_FIN;
                                end else begin
                                    r_bitcnt   <= r_bitcnt - 3'd1;
                                    r_data_out <= r_shreg[r_bitcnt - 3'd1];
                                    r_fclk_out <= BUS_LOW;
                                    r_state    <= FS_LOW;
                                end
                            end else begin
                                r_hp_cnt <= r_hp_cnt + HP_W'(1);
                            end
                        end
                    end
                    FS_FIN: begin
                        r_data_out <= BUS_REL;
                        r_tx_busy  <= 1'b0;
                        r_tx_done  <= 1'b1;
                        r_state    <= FS_IDLE;
                    end
                    default: begin
                        r_state <= FS_IDLE;
                    end
                endcase
            end
        end
    end

    assign w_rx_on       = !dir && !r_tx_busy;
    assign w_rx_complete = w_rx_on && w_fclk_rise && (r_rxcnt == 3'd7);

    // RX shifter, byte hand-off and partial-byte timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_shreg   <= '0;
            r_rxcnt      <= '0;
            r_to_cnt     <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            // A completing byte beats a same-cycle acknowledge
            if (w_rx_complete) begin
                r_rx_data    <= {r_rx_shreg[6:0], w_data_sync};
                r_rx_valid   <= 1'b1;
                r_rx_overrun <= rx_ack ? 1'b0 : (r_rx_overrun | r_rx_valid);
            end else if (rx_ack) begin
                r_rx_valid   <= 1'b0;
                r_rx_overrun <= 1'b0;
            end

            if (!w_rx_on) begin
                r_rxcnt  <= '0;
                r_to_cnt <= '0;
            end else if (w_fclk_rise) begin
                // 3-bit counter wraps 7->0 on the byte-completing rise
                r_rx_shreg <= {r_rx_shreg[6:0], w_data_sync};
                r_rxcnt    <= r_rxcnt + 3'd1;
                r_to_cnt   <= '0;
            end else if (r_rxcnt != 3'd0) begin
                if (ce) begin
                    if (r_to_cnt == TO_LAST) begin
                        r_rxcnt  <= '0;
                        r_to_cnt <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign tx_busy      = r_tx_busy;
    assign tx_done      = r_tx_done;
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_overrun   = r_rx_overrun;
    assign iec_data_out = r_data_out;
    assign iec_fclk_out = r_fclk_out;

endmodule
